// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a uart_8n1_115200 transmitter; a small FSM pops one byte per
// TX_READY handshake and bounds the wait for the UART to acknowledge with a guard counter.
module uart_tx_fifo #(
    parameter int DEPTH = 16,
    parameter int GUARD = 4
) (
    input  logic                     CLK_25MHz,
    input  logic                     RST,
    input  logic                     PUSH,
    input  logic [7:0]               PUSH_DATA,
    output logic                     FULL,
    output logic                     EMPTY,
    output logic [$clog2(DEPTH):0]   COUNT,
    output logic                     OVERFLOW,
    input  logic                     UART_TX_READY,
    output logic                     UART_WE,
    output logic [7:0]               UART_DATA
);
    localparam int AW = $clog2(DEPTH);
    localparam int GW = $clog2(GUARD + 1);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_LOW, WAIT_HIGH} state_t;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    state_t        state;
    logic [GW-1:0] guard_cnt;
    logic          push_ok;
    logic          pop;

    assign FULL    = (COUNT == (AW+1)'(DEPTH));
    assign EMPTY   = (COUNT == '0);
    // FULL is the pre-edge occupancy, so a same-edge pop never frees room for a push.
    assign push_ok = PUSH && !FULL;
    assign pop     = (state == IDLE) && !EMPTY && UART_TX_READY;

    always_ff @(posedge CLK_25MHz) begin
        if (push_ok)
            mem[wr_ptr] <= PUSH_DATA;
    end

    always_ff @(posedge CLK_25MHz) begin
        if (RST) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            COUNT    <= '0;
            OVERFLOW <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (PUSH && FULL)
                OVERFLOW <= 1'b1;
            case ({push_ok, pop})
                2'b10:   COUNT <= COUNT + 1'b1;
                2'b01:   COUNT <= COUNT - 1'b1;
                default: COUNT <= COUNT;
            endcase
        end
    end

    always_ff @(posedge CLK_25MHz) begin
        if (RST) begin
            state     <= IDLE;
            UART_WE   <= 1'b0;
            UART_DATA <= 8'h00;
            guard_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        state     <= SEND;
                        UART_WE   <= 1'b1;
                        UART_DATA <= mem[rd_ptr];
                    end
                end
                SEND: begin
                    state     <= WAIT_LOW;
                    UART_WE   <= 1'b0;
                    guard_cnt <= '0;
                end
                WAIT_LOW: begin
                    // A UART that never drops READY must not stall the queue forever.
                    if (!UART_TX_READY) begin
                        state <= WAIT_HIGH;
                    end else begin
                        guard_cnt <= guard_cnt + 1'b1;
                        if (guard_cnt == GW'(GUARD - 1))
                            state <= IDLE;
                    end
                end
                WAIT_HIGH: begin
                    if (UART_TX_READY)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed checks for uart_tx_fifo with a behavioural UART handshake model
// that drops TX_READY for a fixed time after each WE pulse.
module tb_uart_tx_fifo;
    logic       clk;
    logic       RST;
    logic       PUSH;
    logic [7:0] PUSH_DATA;
    logic       FULL;
    logic       EMPTY;
    logic [4:0] COUNT;
    logic       OVERFLOW;
    logic       READY;
    logic       UART_WE;
    logic [7:0] UART_DATA;

    int total = 0;
    int bad   = 0;

    bit         auto_mode = 0;
    int         busy = 0;
    bit         prev_we = 0;
    bit         had_we = 0;
    bit         ready_low_seen = 0;
    int         we_double = 0;
    int         we_early = 0;
    logic [7:0] cap [$];

    uart_tx_fifo #(.DEPTH(16), .GUARD(4)) dut (
        .CLK_25MHz(clk), .RST(RST), .PUSH(PUSH), .PUSH_DATA(PUSH_DATA),
        .FULL(FULL), .EMPTY(EMPTY), .COUNT(COUNT), .OVERFLOW(OVERFLOW),
        .UART_TX_READY(READY), .UART_WE(UART_WE), .UART_DATA(UART_DATA)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    // Monitor WE pulses, then emulate the UART busy period.
    always @(negedge clk) begin
        if (UART_WE) begin
            cap.push_back(UART_DATA);
            if (prev_we) we_double++;
            if (had_we && !ready_low_seen) we_early++;
            had_we = 1;
            ready_low_seen = 0;
        end else if (READY == 1'b0) begin
            ready_low_seen = 1;
        end
        prev_we = UART_WE;
        if (auto_mode) begin
            if (UART_WE) begin
                busy = 8;
                READY = 1'b0;
            end else if (busy > 0) begin
                busy--;
                if (busy == 0) READY = 1'b1;
            end
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        RST = 1'b1; PUSH = 1'b0; PUSH_DATA = 8'h00; READY = 1'b0; auto_mode = 0;
        step();
        RST = 1'b0;
        cap.delete();
        had_we = 0; we_double = 0; we_early = 0; busy = 0;
    endtask

    task automatic test_reset();
        RST = 1'b1; PUSH = 1'b1; PUSH_DATA = 8'hAA; READY = 1'b1;
        step();
        total++; if (COUNT !== 5'd0)  begin bad++; $display("FAIL reset_count got=%0d exp=0", COUNT); end
        total++; if (EMPTY !== 1'b1)  begin bad++; $display("FAIL reset_empty got=%b exp=1", EMPTY); end
        total++; if (FULL !== 1'b0)   begin bad++; $display("FAIL reset_full got=%b exp=0", FULL); end
        total++; if (OVERFLOW !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", OVERFLOW); end
        total++; if (UART_WE !== 1'b0) begin bad++; $display("FAIL reset_we got=%b exp=0", UART_WE); end
        total++; if (UART_DATA !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", UART_DATA); end
        PUSH = 1'b0; RST = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        READY = 1'b1; PUSH = 1'b1; PUSH_DATA = 8'h48;
        step();
        PUSH = 1'b0;
        total++; if (COUNT !== 5'd1) begin bad++; $display("FAIL single_count got=%0d exp=1", COUNT); end
        total++; if (UART_WE !== 1'b0) begin bad++; $display("FAIL single_we_early got=%b exp=0", UART_WE); end
        step();
        total++; if (UART_WE !== 1'b1) begin bad++; $display("FAIL single_we got=%b exp=1", UART_WE); end
        total++; if (UART_DATA !== 8'h48) begin bad++; $display("FAIL single_data got=%h exp=48", UART_DATA); end
        total++; if (EMPTY !== 1'b1) begin bad++; $display("FAIL single_empty got=%b exp=1", EMPTY); end
        step();
        total++; if (UART_WE !== 1'b0) begin bad++; $display("FAIL single_we_once got=%b exp=0", UART_WE); end
        total++; if (UART_DATA !== 8'h48) begin bad++; $display("FAIL single_data_hold got=%h exp=48", UART_DATA); end
    endtask

    task automatic test_guard();
        do_reset();
        READY = 1'b1; PUSH = 1'b1; PUSH_DATA = 8'hA1;
        step();
        PUSH_DATA = 8'hA2;
        step();
        PUSH = 1'b0;
        total++; if (UART_WE !== 1'b1 || UART_DATA !== 8'hA1) begin bad++; $display("FAIL guard_first got=%b/%h exp=1/a1", UART_WE, UART_DATA); end
        // SEND, four WAIT_LOW cycles, IDLE, then the next SEND.
        for (int i = 1; i <= 6; i++) begin
            step();
            if (i < 6) begin
                total++; if (UART_WE !== 1'b0) begin bad++; $display("FAIL guard_gap%0d got=%b exp=0", i, UART_WE); end
            end else begin
                total++; if (UART_WE !== 1'b1 || UART_DATA !== 8'hA2) begin bad++; $display("FAIL guard_second got=%b/%h exp=1/a2", UART_WE, UART_DATA); end
            end
        end
    endtask

    task automatic test_burst();
        logic [7:0] exp [5];
        exp[0] = 8'h48; exp[1] = 8'h65; exp[2] = 8'h6C; exp[3] = 8'h6C; exp[4] = 8'h6F;
        do_reset();
        READY = 1'b1; auto_mode = 1;
        for (int i = 0; i < 5; i++) begin
            PUSH = 1'b1; PUSH_DATA = exp[i];
            step();
        end
        PUSH = 1'b0;
        for (int i = 0; i < 400 && cap.size() < 5; i++) step();
        for (int i = 0; i < 40; i++) step();
        total++; if (cap.size() !== 5) begin bad++; $display("FAIL burst_pulses got=%0d exp=5", cap.size()); end
        for (int i = 0; i < 5 && i < cap.size(); i++) begin
            total++; if (cap[i] !== exp[i]) begin bad++; $display("FAIL burst_byte%0d got=%h exp=%h", i, cap[i], exp[i]); end
        end
        total++; if (we_early !== 0) begin bad++; $display("FAIL burst_we_before_ready got=%0d exp=0", we_early); end
        total++; if (we_double !== 0) begin bad++; $display("FAIL burst_we_width got=%0d exp=0", we_double); end
        auto_mode = 0;
    endtask

    task automatic test_full();
        do_reset();
        READY = 1'b0;
        for (int i = 0; i < 16; i++) begin
            PUSH = 1'b1; PUSH_DATA = 8'(i);
            step();
        end
        total++; if (FULL !== 1'b1 || COUNT !== 5'd16 || OVERFLOW !== 1'b0) begin bad++; $display("FAIL full_16 got=%b/%0d/%b exp=1/16/0", FULL, COUNT, OVERFLOW); end
        PUSH_DATA = 8'h10;
        step();
        PUSH = 1'b0;
        total++; if (FULL !== 1'b1 || COUNT !== 5'd16) begin bad++; $display("FAIL full_17 got=%b/%0d exp=1/16", FULL, COUNT); end
        total++; if (OVERFLOW !== 1'b1) begin bad++; $display("FAIL full_ovf got=%b exp=1", OVERFLOW); end
        READY = 1'b1; auto_mode = 1;
        for (int i = 0; i < 600 && cap.size() < 16; i++) step();
        for (int i = 0; i < 60; i++) step();
        total++; if (cap.size() !== 16) begin bad++; $display("FAIL full_drain_n got=%0d exp=16", cap.size()); end
        for (int i = 0; i < 16 && i < cap.size(); i++) begin
            total++; if (cap[i] !== 8'(i)) begin bad++; $display("FAIL full_drain%0d got=%h exp=%h", i, cap[i], 8'(i)); end
        end
        total++; if (EMPTY !== 1'b1 || OVERFLOW !== 1'b1) begin bad++; $display("FAIL full_end got=%b/%b exp=1/1", EMPTY, OVERFLOW); end
        auto_mode = 0;
    endtask

    task automatic test_simul();
        do_reset();
        READY = 1'b0;
        for (int i = 0; i < 16; i++) begin
            PUSH = 1'b1; PUSH_DATA = 8'(8'h20 + i);
            step();
        end
        total++; if (COUNT !== 5'd16 || OVERFLOW !== 1'b0) begin bad++; $display("FAIL simul_pre got=%0d/%b exp=16/0", COUNT, OVERFLOW); end
        READY = 1'b1; PUSH_DATA = 8'h99;
        step();
        PUSH = 1'b0; READY = 1'b0;
        total++; if (COUNT !== 5'd15) begin bad++; $display("FAIL simul_count got=%0d exp=15", COUNT); end
        total++; if (OVERFLOW !== 1'b1) begin bad++; $display("FAIL simul_ovf got=%b exp=1", OVERFLOW); end
        total++; if (UART_WE !== 1'b1 || UART_DATA !== 8'h20) begin bad++; $display("FAIL simul_pop got=%b/%h exp=1/20", UART_WE, UART_DATA); end
        RST = 1'b1;
        step();
        RST = 1'b0;
        total++; if (OVERFLOW !== 1'b0) begin bad++; $display("FAIL simul_ovf_clear got=%b exp=0", OVERFLOW); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        READY = 1'b1; PUSH = 1'b1; PUSH_DATA = 8'hC0;
        step();
        PUSH_DATA = 8'hC1;
        step();
        PUSH_DATA = 8'hC2;
        step();
        PUSH_DATA = 8'hC3; READY = 1'b0;
        step();
        PUSH = 1'b0;
        total++; if (COUNT !== 5'd3 || UART_WE !== 1'b0) begin bad++; $display("FAIL mid_pre got=%0d/%b exp=3/0", COUNT, UART_WE); end
        RST = 1'b1; PUSH = 1'b1; PUSH_DATA = 8'hEE;
        step();
        RST = 1'b0; PUSH = 1'b0;
        total++; if (COUNT !== 5'd0 || EMPTY !== 1'b1) begin bad++; $display("FAIL mid_count got=%0d/%b exp=0/1", COUNT, EMPTY); end
        total++; if (UART_WE !== 1'b0 || OVERFLOW !== 1'b0) begin bad++; $display("FAIL mid_we_ovf got=%b/%b exp=0/0", UART_WE, OVERFLOW); end
        READY = 1'b1; PUSH = 1'b1; PUSH_DATA = 8'h5A;
        step();
        PUSH = 1'b0;
        total++; if (UART_WE !== 1'b0 || COUNT !== 5'd1) begin bad++; $display("FAIL mid_idle1 got=%b/%0d exp=0/1", UART_WE, COUNT); end
        step();
        total++; if (UART_WE !== 1'b1 || UART_DATA !== 8'h5A) begin bad++; $display("FAIL mid_idle2 got=%b/%h exp=1/5a", UART_WE, UART_DATA); end
    endtask

    initial begin
        RST = 1'b1; PUSH = 1'b0; PUSH_DATA = 8'h00; READY = 1'b0;
        step();
        test_reset();
        test_single();
        test_guard();
        test_burst();
        test_full();
        test_simul();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter DEPTH, default 16, FIFO entries; SHALL be a power of two, 2 to 256.
REQ-002 Parameter GUARD, default 4, max cycles in WAIT_LOW before abandoning the wait.
REQ-003 CLK_25MHz  in  1  sole clock; all state SHALL update on its rising edge.
REQ-004 RST  in  1  synchronous, active-high reset.
REQ-005 PUSH  in  1  write strobe from host; one byte per high cycle.
REQ-006 PUSH_DATA  in  8  byte to enqueue.
REQ-007 FULL  out  1  high when COUNT == DEPTH.
REQ-008 EMPTY  out  1  high when COUNT == 0.
REQ-009 COUNT  out  log2(DEPTH)+1  current occupancy.
REQ-010 OVERFLOW  out  1  sticky; set when a push is dropped.
REQ-011 UART_TX_READY  in  1  TX_READY from downstream uart_8n1_115200.
REQ-012 UART_WE  out  1  drives uart_8n1_115200 WE.
REQ-013 UART_DATA  out  8  drives uart_8n1_115200 DATA_IN.

Function
REQ-014 Storage SHALL be a circular buffer with registered read/write pointers that wrap modulo DEPTH.
REQ-015 Push accepted iff PUSH=1 and FULL=0 at the edge; accepted byte written at write pointer, pointer increments.
REQ-016 PUSH=1 while FULL=1 SHALL leave FIFO contents, pointers and COUNT unchanged and set OVERFLOW.
REQ-017 Push gating SHALL use FULL as registered before the edge; a same-edge pop SHALL NOT admit a push into a full FIFO.
REQ-018 Push and pop at the same edge SHALL leave COUNT unchanged and advance both pointers.
REQ-019 FIFO order SHALL be strict; bytes leave in acceptance order with no duplication or loss.
REQ-020 FSM states: IDLE, SEND, WAIT_LOW, WAIT_HIGH.
REQ-021 IDLE -> SEND at an edge where EMPTY=0 and UART_TX_READY=1; otherwise stay in IDLE.
REQ-022 On the IDLE->SEND edge, UART_DATA SHALL load the head byte and the read pointer SHALL advance (pop).
REQ-023 In SEND, UART_WE=1 for exactly that one cycle; UART_WE=0 in every other state.
REQ-024 SEND -> WAIT_LOW unconditionally; a guard counter clears to 0.
REQ-025 WAIT_LOW -> WAIT_HIGH when UART_TX_READY=0; otherwise the counter increments and, when it reaches GUARD, the FSM returns to IDLE.
REQ-026 WAIT_HIGH -> IDLE when UART_TX_READY=1.
REQ-027 UART_DATA SHALL hold its value from SEND until the next SEND.
REQ-028 Latency: a push accepted at edge N into an empty FIFO, with FSM in IDLE and UART_TX_READY=1, gives UART_WE=1 in the cycle following edge N+1.
REQ-029 Bytes SHALL NOT be lost or reordered while the FSM waits; pushes are accepted in every FSM state.

Reset
REQ-030 With RST=1 at an edge: pointers=0, COUNT=0, EMPTY=1, FULL=0, OVERFLOW=0, FSM=IDLE, UART_WE=0, UART_DATA=8'h00, guard counter=0.
REQ-031 RST overrides PUSH and the FSM on the same edge; buffered bytes are discarded, including a byte mid-handshake.
REQ-032 Memory contents need not be cleared by reset.

Verification
REQ-033 Single byte: push 8'h48 with the FSM idle and the UART idle -> UART_WE high for one cycle two edges later, UART_DATA=8'h48, EMPTY=1 afterwards.
REQ-034 Burst: push 8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F on consecutive cycles into a real uart_8n1_115200 -> exactly five WE pulses; TX_LINE carries the bytes in order; each WE occurs only after TX_READY returns high.
REQ-035 Full/overflow (DEPTH=16, UART_TX_READY held 0): push 17 bytes 8'h00..8'h10 -> FULL=1, COUNT=16, OVERFLOW=1; after releasing READY, bytes 8'h00..8'h0F drain and 8'h10 never appears.
REQ-036 Simultaneous: at COUNT=16, PUSH=1 on the edge where a pop occurs -> push rejected, COUNT=15, OVERFLOW=1.
REQ-037 Guard timeout: UART_TX_READY stuck at 1 -> after SEND, the FSM returns to IDLE after GUARD=4 cycles, and the next byte's WE follows; no deadlock.
REQ-038 Reset mid-operation: assert RST during WAIT_HIGH with COUNT=3 -> next cycle COUNT=0, EMPTY=1, UART_WE=0, FSM=IDLE, OVERFLOW=0.
